// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the pipeline and a single-port synchronous word memory.
// Sub-word stores are done as read-modify-write; loads are lane-selected and extended.
module lsu_mem_ctrl #(
  parameter int unsigned MEMORY_SIZE = 2048,
  parameter int unsigned ADDR_WIDTH  = $clog2(MEMORY_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {
    StIdle, StLdAddr, StLdData, StStWr, StRmwRd, StRmwWr, StResp
  } state_e;

  state_e      state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] wdata_word_q;
  logic        req_err;
  logic [31:0] load_ext;
  logic [31:0] rmw_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Bits above the word address are ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  assign req_ready = (state_q == StIdle) && !rst;

  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000:  req_err = 1'b0;
        3'b001:  req_err = req_addr[0];
        3'b010:  req_err = |req_addr[1:0];
        default: req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: req_err = 1'b0;
        3'b001, 3'b101: req_err = req_addr[0];
        3'b010:         req_err = |req_addr[1:0];
        default:        req_err = 1'b1;
      endcase
    end
  end

  assign ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
  assign ld_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = mem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'h0, ld_byte};
      3'b101:  load_ext = {16'h0, ld_half};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    rmw_word = mem_rdata;
    if (funct3_q[0]) rmw_word[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    else             rmw_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
  end

  // Merged word is combinational: the read data only arrives during the write cycle.
  assign mem_wdata = (state_q == StRmwWr) ? rmw_word : wdata_word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      wdata_word_q <= 32'h0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_re       <= 1'b0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= 32'h0;
    end else begin
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      resp_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            mem_addr <= req_addr[ADDR_WIDTH+1:2];
            if (req_err) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_we && req_funct3 == 3'b010) begin
              state_q      <= StStWr;
              mem_we       <= 1'b1;
              wdata_word_q <= req_wdata;
            end else if (req_we) begin
              state_q <= StRmwRd;
              mem_re  <= 1'b1;
            end else begin
              state_q <= StLdAddr;
              mem_re  <= 1'b1;
            end
          end
        end
        StLdAddr: state_q <= StLdData;
        StLdData: begin
          state_q    <= StResp;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_ext;
        end
        StRmwRd: begin
          state_q <= StRmwWr;
          mem_we  <= 1'b1;
        end
        StStWr, StRmwWr: begin
          state_q    <= StResp;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against a byte-array memory model.
module tb_lsu_mem_ctrl;
  localparam int unsigned MS = 64;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  logic [31:0]   ram [MS];
  logic [7:0]    rbytes [MS*4];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = 32'h0;

  int checks = 0;
  int errors = 0;

  lsu_mem_ctrl #(.MEMORY_SIZE(MS), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    else mem_rdata <= ram[mem_addr];
  end

  function automatic logic [31:0] model_word(input int w);
    return {rbytes[w*4+3], rbytes[w*4+2], rbytes[w*4+1], rbytes[w*4]};
  endfunction

  // One full transaction with reference expectations derived from the byte model.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] got);
    int b, wa, lat, we_cnt, re_cnt, we_cyc, exp_lat, exp_re, exp_we, waitc;
    logic exp_err, addr_bad;
    logic [31:0] exp_rd, exp_word, wd_seen;
    logic [15:0] h;
    b = int'(addr[AW+1:0]);
    wa = int'(addr[AW+1:2]);
    if (we) begin
      case (f3)
        3'd0:    exp_err = 1'b0;
        3'd1:    exp_err = addr[0];
        3'd2:    exp_err = addr[1:0] != 2'b00;
        default: exp_err = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: exp_err = 1'b0;
        3'd1, 3'd5: exp_err = addr[0];
        3'd2:       exp_err = addr[1:0] != 2'b00;
        default:    exp_err = 1'b1;
      endcase
    end
    exp_rd = 32'h0;
    h = {rbytes[(b+1)%(MS*4)], rbytes[b]};
    if (!exp_err && !we) begin
      case (f3)
        3'd0:    exp_rd = {{24{rbytes[b][7]}}, rbytes[b]};
        3'd4:    exp_rd = {24'h0, rbytes[b]};
        3'd1:    exp_rd = {{16{h[15]}}, h};
        3'd5:    exp_rd = {16'h0, h};
        default: exp_rd = model_word(wa);
      endcase
    end
    if (!exp_err && we) begin
      rbytes[b] = wdata[7:0];
      if (f3 != 3'd0) rbytes[b+1] = wdata[15:8];
      if (f3 == 3'd2) begin
        rbytes[b+2] = wdata[23:16];
        rbytes[b+3] = wdata[31:24];
      end
    end
    exp_word = model_word(wa);
    exp_lat = exp_err ? 1 : (we && f3 == 3'd2) ? 2 : 3;
    exp_we = (!exp_err && we) ? 1 : 0;
    exp_re = (!exp_err && !(we && f3 == 3'd2)) ? 1 : 0;

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got %b want 1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; we_cnt = 0; re_cnt = 0; we_cyc = 0; addr_bad = 1'b0; wd_seen = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_cyc = k; wd_seen = mem_wdata; end
      if (mem_re) re_cnt++;
      if ((mem_we || mem_re) && mem_addr !== AW'(wa)) addr_bad = 1'b1;
      if (resp_valid) begin lat = k; break; end
    end
    got = resp_rdata;
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency addr=%h f3=%0d we=%b got %0d want %0d", addr, f3, we, lat, exp_lat);
    end
    checks++;
    if (resp_err !== exp_err) begin
      errors++;
      $display("FAIL resp_err addr=%h f3=%0d we=%b got %b want %b", addr, f3, we, resp_err, exp_err);
    end
    checks++;
    if (resp_rdata !== exp_rd) begin
      errors++;
      $display("FAIL rdata addr=%h f3=%0d got %h want %h", addr, f3, resp_rdata, exp_rd);
    end
    checks++;
    if (we_cnt != exp_we || re_cnt != exp_re) begin
      errors++;
      $display("FAIL mem_pulses addr=%h f3=%0d we=%b got we%0d re%0d want we%0d re%0d",
               addr, f3, we, we_cnt, re_cnt, exp_we, exp_re);
    end
    checks++;
    if (addr_bad) begin
      errors++;
      $display("FAIL mem_addr addr=%h got bad want %0d", addr, wa);
    end
    if (we_cnt == 1) begin
      checks++;
      if (wd_seen !== exp_word || we_cyc != exp_lat - 1) begin
        errors++;
        $display("FAIL write addr=%h f3=%0d got %h@%0d want %h@%0d",
                 addr, f3, wd_seen, we_cyc, exp_word, exp_lat - 1);
      end
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== exp_rd ||
        resp_err !== exp_err) begin
      errors++;
      $display("FAIL resp_hold got v%b r%b d%h e%b want v0 r1 d%h e%b",
               resp_valid, req_ready, resp_rdata, resp_err, exp_rd, exp_err);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < int'(MS); i++) begin
      @(negedge clk);
      pre_en = 1'b1; pre_addr = AW'(i);
      pre_data = (i == 4) ? 32'h8081F2F3 : $urandom;
      rbytes[i*4] = pre_data[7:0];     rbytes[i*4+1] = pre_data[15:8];
      rbytes[i*4+2] = pre_data[23:16]; rbytes[i*4+3] = pre_data[31:24];
    end
    @(negedge clk);
    pre_en = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
        resp_rdata !== 32'h0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got r%b v%b e%b d%h we%b re%b want all zero",
               req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_re);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem got a%h d%h want 0 0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed;
    logic [31:0] got;
    txn(1'b0, 3'd0, 32'h11, 32'h0, got);
    checks++;
    if (got !== 32'hFFFFFFF2) begin errors++; $display("FAIL lb got %h want FFFFFFF2", got); end
    txn(1'b0, 3'd4, 32'h12, 32'h0, got);
    checks++;
    if (got !== 32'h00000081) begin errors++; $display("FAIL lbu got %h want 00000081", got); end
    txn(1'b0, 3'd1, 32'h12, 32'h0, got);
    checks++;
    if (got !== 32'hFFFF8081) begin errors++; $display("FAIL lh got %h want FFFF8081", got); end
    txn(1'b0, 3'd5, 32'h10, 32'h0, got);
    checks++;
    if (got !== 32'h0000F2F3) begin errors++; $display("FAIL lhu got %h want 0000F2F3", got); end
    txn(1'b0, 3'd2, 32'h10, 32'h0, got);
    checks++;
    if (got !== 32'h8081F2F3) begin errors++; $display("FAIL lw got %h want 8081F2F3", got); end
    txn(1'b1, 3'd0, 32'h13, 32'h000000AA, got);
    txn(1'b0, 3'd2, 32'h10, 32'h0, got);
    checks++;
    if (got !== 32'hAA81F2F3) begin errors++; $display("FAIL sb_lw got %h want AA81F2F3", got); end
    txn(1'b1, 3'd2, 32'h06, 32'h12345678, got);
    txn(1'b0, 3'd2, 32'h1000_0010, 32'h0, got);
    checks++;
    if (got !== 32'hAA81F2F3) begin errors++; $display("FAIL wrap got %h want AA81F2F3", got); end
  endtask

  task automatic test_reset_mid;
    logic saw_we, saw_v;
    saw_we = 1'b0; saw_v = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h10; req_wdata = 32'h5A5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (mem_re !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got re%b r%b want re0 r0", mem_re, req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_we) saw_we = 1'b1;
      if (resp_valid) saw_v = 1'b1;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_abort got %b want 1", req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_we) saw_we = 1'b1;
      if (resp_valid) saw_v = 1'b1;
    end
    checks++;
    if (saw_we || saw_v || ram[4] !== model_word(4)) begin
      errors++;
      $display("FAIL abort got we%b v%b word %h want we0 v0 word %h",
               saw_we, saw_v, ram[4], model_word(4));
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    int first_ready, we_cnt, lat;
    d = $urandom;
    first_ready = 0; we_cnt = 0; lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = d;
    @(posedge clk);
    #1 req_we = 1'b0; req_wdata = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (req_ready) begin first_ready = k; break; end
    end
    checks++;
    if (first_ready != 3 || we_cnt != 1) begin
      errors++;
      $display("FAIL b2b_busy got ready@%0d we%0d want ready@3 we1", first_ready, we_cnt);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (resp_valid) begin lat = k; break; end
    end
    checks++;
    if (lat != 3 || resp_rdata !== d) begin
      errors++;
      $display("FAIL b2b_load got lat%0d d%h want lat3 d%h", lat, resp_rdata, d);
    end
    rbytes[32] = d[7:0];   rbytes[33] = d[15:8];
    rbytes[34] = d[23:16]; rbytes[35] = d[31:24];
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] got, addr;
    logic [2:0] f3;
    logic we;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) addr[0] = 1'b0;
        if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
      end
      txn(we, f3, addr, $urandom, got);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter MEMORY_SIZE, default 2048: data memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(MEMORY_SIZE): word-address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: pipeline access request.
REQ-006 SHALL have port req_ready, output, 1 bit: the controller can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3 bits: RISC-V funct3, giving access size and extension.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32 bits: extended load result.
REQ-013 SHALL have port resp_err, output, 1 bit: misaligned or illegal access, qualified by resp_valid.
REQ-014 SHALL have port mem_addr, output, ADDR_WIDTH bits: word address to the data memory.
REQ-015 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-016 SHALL have port mem_re, output, 1 bit: memory read enable.
REQ-017 SHALL have port mem_wdata, output, 32 bits: memory write data.
REQ-018 SHALL have port mem_rdata, input, 32 bits: memory read data, valid one cycle after an address is presented with mem_we=0.

Function
REQ-019 SHALL implement FSM states IDLE, LD_ADDR, LD_DATA, ST_WR, RMW_RD, RMW_WR, RESP.
REQ-020 SHALL drive req_ready=1 only in IDLE with rst low; a request is accepted on the edge where req_valid&&req_ready, latching req_we, req_funct3, req_addr and req_wdata.
REQ-021 SHALL form word address = req_addr[ADDR_WIDTH+1:2]; upper bits ignored (address wraps); byte order little-endian.
REQ-022 SHALL treat these as errors: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 011/110/111; store funct3 other than 000/001/010.
REQ-023 Error path SHALL be IDLE->RESP with resp_err=1 and no mem_we or mem_re pulse; response one cycle after acceptance.
REQ-024 Load path SHALL be IDLE->LD_ADDR (mem_re=1, mem_addr driven)->LD_DATA (mem_rdata sampled, extended, registered)->RESP; resp_valid three cycles after acceptance.
REQ-025 Load extension SHALL be: LB/LH sign-extend the selected byte/halfword, LBU/LHU zero-extend, LW pass the word; the lane is selected by addr[1:0].
REQ-026 SW SHALL be IDLE->ST_WR (mem_we=1, mem_wdata=req_wdata)->RESP; resp_valid two cycles after acceptance.
REQ-027 SB/SH SHALL be IDLE->RMW_RD (mem_re=1)->RMW_WR (mem_we=1, mem_wdata = mem_rdata with the addressed lane replaced by req_wdata[7:0]/[15:0])->RESP; resp_valid three cycles after acceptance.
REQ-028 mem_we SHALL be high for exactly one cycle per store and never for loads or errors; mem_addr SHALL stay stable from the first access cycle through the write cycle.
REQ-029 RESP SHALL last exactly one cycle and then return to IDLE; resp_rdata and resp_err SHALL hold until the next response; resp_rdata=0 for stores and errors.
REQ-030 Requests presented while req_ready=0 SHALL be ignored; there is no queueing, so the next acceptance can occur no earlier than the cycle after RESP.

Reset
REQ-031 rst SHALL asynchronously force: state IDLE, mem_we=0, mem_re=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, req_ready=0 while asserted.
REQ-032 Reset mid-operation SHALL abort without response; a write not yet clocked into memory SHALL NOT occur.
REQ-033 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-034 Preload word 4 = 0x8081F2F3; LB 0x11 -> resp_rdata=0xFFFFFFF2; LBU 0x12 -> 0x00000081; each resp_valid 3 cycles after acceptance.
REQ-035 Same word; LH 0x12 -> 0xFFFF8081; LHU 0x10 -> 0x0000F2F3; LW 0x10 -> 0x8081F2F3.
REQ-036 SB 0x13 wdata 0x000000AA -> single mem_we pulse 2 cycles after acceptance, mem_wdata=0xAA81F2F3; subsequent LW 0x10 -> 0xAA81F2F3.
REQ-037 SW 0x06 -> resp_valid with resp_err=1 one cycle after acceptance; mem_we and mem_re never asserted.
REQ-038 SH 0x10 with rst asserted during RMW_RD -> no mem_we pulse, no resp_valid, word unchanged; req_ready=1 the cycle after release.
REQ-039 Back-to-back req_valid held high for SW then LW -> second request accepted only after RESP; busy-cycle requests ignored.
